// File: rtl/clock_div_mux_pkg.sv
// clock_div_mux_pkg: shared types and helpers for the clock-enable divider/selector
//   sel_width()    : select width for a channel count, never below 1
//   CEIL_HALF_BIAS : bias so that ceil((R+1)/2) == (R + CEIL_HALF_BIAS) >> 1
//   sel_state_t    : channel-switch handshake states
package clock_div_mux_pkg;
    localparam int CEIL_HALF_BIAS = 2;
    typedef enum logic {SEL_IDLE, SEL_PENDING} sel_state_t;
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/clock_div_counter.sv
// clock_div_counter: period counter producing terminal, enable pulse and divided clock
//   clk, rst   : clock, asynchronous active-high reset
//   ratio      : live divide ratio R, period is R+1 cycles
//   terminal   : combinational, high in the last cycle of a period
//   clk_enable : registered, high in the cycle after terminal
//   clk_div    : registered, high for the first ceil((R+1)/2) cycles of a period
module clock_div_counter
    import clock_div_mux_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] ratio,
    output logic                 terminal,
    output logic                 clk_enable,
    output logic                 clk_div
);
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_n;
    logic [CNT_WIDTH:0]   half;
    // >= rather than == so a ratio lowered below the count wraps immediately
    assign terminal = count >= ratio;
    assign count_n  = terminal ? '0 : count + 1'b1;
    // one extra bit keeps R = 2^CNT_WIDTH-1 from overflowing
    assign half     = ({1'b0, ratio} + (CNT_WIDTH+1)'(CEIL_HALF_BIAS)) >> 1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            clk_enable <= 1'b0;
            clk_div    <= 1'b0;
        end else begin
            count      <= count_n;
            clk_enable <= terminal;
            clk_div    <= {1'b0, count_n} < half;
        end
    end
endmodule

// File: rtl/clock_div_mux.sv
// clock_div_mux: N-channel clock-enable divider with glitch-free handshaked channel select
//   clk, rst       : clock, asynchronous active-high reset
//   div_ratio      : per-channel ratio, channel i at [i*CNT_WIDTH +: CNT_WIDTH]
//   select_req     : switch request valid, accepted when select_ready
//   select         : requested channel
//   select_ready   : no switch pending
//   select_ack     : one-cycle pulse when current_select takes the new value
//   select_err     : one-cycle pulse after a request for a channel >= NUM_CH
//   current_select : channel driving the outputs
//   clk_enable     : one-cycle pulse per period of the active channel
//   clk_div        : registered divided clock of the active channel
module clock_div_mux
    import clock_div_mux_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_SEL = 0,
    parameter int SEL_W       = sel_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH*CNT_WIDTH-1:0] div_ratio,
    input  logic                        select_req,
    output logic                        select_ready,
    input  logic [SEL_W-1:0]            select,
    output logic                        select_ack,
    output logic                        select_err,
    output logic [SEL_W-1:0]            current_select,
    output logic                        clk_enable,
    output logic                        clk_div
);
    // SEL_W+1 bits so NUM_CH == 2^SEL_W does not truncate to zero
    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
    sel_state_t           state;
    sel_state_t           state_n;
    logic [SEL_W-1:0]     pending_sel;
    logic [SEL_W-1:0]     pending_n;
    logic [SEL_W-1:0]     cur_n;
    logic                 ack_n;
    logic                 err_n;
    logic                 terminal;
    logic [CNT_WIDTH-1:0] active_ratio;
    // padded to a power of two so any select code indexes a defined entry
    logic [CNT_WIDTH-1:0] ratios [2**SEL_W];
    for (genvar i = 0; i < 2**SEL_W; i++) begin : g_ratio
        if (i < NUM_CH) begin : g_used
            assign ratios[i] = div_ratio[i*CNT_WIDTH +: CNT_WIDTH];
        end else begin : g_unused
            assign ratios[i] = '0;
        end
    end
    assign active_ratio = ratios[current_select];
    clock_div_counter #(.CNT_WIDTH(CNT_WIDTH)) u_counter (
        .clk        (clk),
        .rst        (rst),
        .ratio      (active_ratio),
        .terminal   (terminal),
        .clk_enable (clk_enable),
        .clk_div    (clk_div)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= SEL_IDLE;
            pending_sel    <= '0;
            current_select <= SEL_W'(DEFAULT_SEL);
            select_ack     <= 1'b0;
            select_err     <= 1'b0;
        end else begin
            state          <= state_n;
            pending_sel    <= pending_n;
            current_select <= cur_n;
            select_ack     <= ack_n;
            select_err     <= err_n;
        end
    end
    // the switch lands on a terminal cycle, where the counter wraps to 0 anyway
    always_comb begin
        state_n      = state;
        pending_n    = pending_sel;
        cur_n        = current_select;
        ack_n        = 1'b0;
        err_n        = 1'b0;
        select_ready = state == SEL_IDLE;
        if (state == SEL_IDLE) begin
            if (select_req && ({1'b0, select} < NCH)) begin
                state_n   = SEL_PENDING;
                pending_n = select;
            end else if (select_req) begin
                err_n = 1'b1;
            end
        end else if (terminal) begin
            state_n = SEL_IDLE;
            cur_n   = pending_sel;
            ack_n   = 1'b1;
        end
    end
endmodule

// File: tb/tb_clock_div_mux.sv
// tb_clock_div_mux: directed self-checking bench for clock_div_mux (NUM_CH=5, CNT_WIDTH=8)
module tb_clock_div_mux;
    logic        clk;
    logic        rst;
    logic [39:0] div_ratio;
    logic        select_req;
    logic        select_ready;
    logic [2:0]  select;
    logic        select_ack;
    logic        select_err;
    logic [2:0]  current_select;
    logic        clk_enable;
    logic        clk_div;
    int total;
    int bad;

    clock_div_mux #(.NUM_CH(5), .CNT_WIDTH(8), .DEFAULT_SEL(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .div_ratio      (div_ratio),
        .select_req     (select_req),
        .select_ready   (select_ready),
        .select         (select),
        .select_ack     (select_ack),
        .select_err     (select_err),
        .current_select (current_select),
        .clk_enable     (clk_enable),
        .clk_div        (clk_div)
    );

    always #5 clk = ~clk;

    task automatic set_r(input int ch, input int r);
        div_ratio[ch*8 +: 8] = r[7:0];
    endtask

    // leaves the bench at a negedge with reset released; next posedge is cycle 1
    task automatic reset_dut();
        rst = 1'b1;
        select_req = 1'b0;
        select = 3'd0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        div_ratio = '0;
        set_r(0, 3);
        reset_dut();
        total++; if (current_select !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", current_select); end
        total++; if (select_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", select_ready); end
        total++; if (select_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", select_ack); end
        total++; if (select_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", select_err); end
        total++; if (clk_enable !== 1'b0) begin bad++; $display("FAIL reset_en: got %b want 0", clk_enable); end
        total++; if (clk_div !== 1'b0) begin bad++; $display("FAIL reset_div: got %b want 0", clk_div); end
    endtask

    // R0=3: counter 1,2,3,0,... ; inactive channel 3 churns without effect
    task automatic test_div3();
        logic [7:0] en_v;
        logic [7:0] div_v;
        en_v  = 8'b1000_1000;
        div_v = 8'b1001_1001;
        div_ratio = '0;
        set_r(0, 3);
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            set_r(3, k * 7);
            @(negedge clk);
            total++; if (clk_enable !== en_v[k]) begin bad++; $display("FAIL div3_en[%0d]: got %b want %b", k, clk_enable, en_v[k]); end
            total++; if (clk_div !== div_v[k]) begin bad++; $display("FAIL div3_div[%0d]: got %b want %b", k, clk_div, div_v[k]); end
        end
        total++; if (current_select !== 3'd0) begin bad++; $display("FAIL div3_sel: got %0d want 0", current_select); end
    endtask

    task automatic test_switch();
        div_ratio = '0;
        set_r(0, 3);
        set_r(1, 1);
        reset_dut();
        @(negedge clk);
        select_req = 1'b1;
        select = 3'd1;
        @(negedge clk);
        select_req = 1'b0;
        total++; if (select_ready !== 1'b0) begin bad++; $display("FAIL sw_ready_low: got %b want 0", select_ready); end
        total++; if (current_select !== 3'd0) begin bad++; $display("FAIL sw_sel_early: got %0d want 0", current_select); end
        @(negedge clk);
        total++; if (select_ack !== 1'b0) begin bad++; $display("FAIL sw_ack_early: got %b want 0", select_ack); end
        @(negedge clk);
        total++; if (current_select !== 3'd1) begin bad++; $display("FAIL sw_sel: got %0d want 1", current_select); end
        total++; if (select_ack !== 1'b1) begin bad++; $display("FAIL sw_ack: got %b want 1", select_ack); end
        total++; if (select_ready !== 1'b1) begin bad++; $display("FAIL sw_ready_back: got %b want 1", select_ready); end
        total++; if (clk_enable !== 1'b1) begin bad++; $display("FAIL sw_en_wrap: got %b want 1", clk_enable); end
        @(negedge clk);
        total++; if (select_ack !== 1'b0) begin bad++; $display("FAIL sw_ack_once: got %b want 0", select_ack); end
        total++; if ({clk_div, clk_enable} !== 2'b00) begin bad++; $display("FAIL sw_p2_a: got %b want 00", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b11) begin bad++; $display("FAIL sw_p2_b: got %b want 11", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b00) begin bad++; $display("FAIL sw_p2_c: got %b want 00", {clk_div, clk_enable}); end
    endtask

    task automatic test_err();
        div_ratio = '0;
        set_r(0, 3);
        reset_dut();
        @(negedge clk);
        select_req = 1'b1;
        select = 3'd5;
        @(negedge clk);
        select_req = 1'b0;
        total++; if (select_err !== 1'b1) begin bad++; $display("FAIL err5_pulse: got %b want 1", select_err); end
        total++; if (select_ready !== 1'b1) begin bad++; $display("FAIL err5_ready: got %b want 1", select_ready); end
        total++; if (current_select !== 3'd0) begin bad++; $display("FAIL err5_sel: got %0d want 0", current_select); end
        total++; if ({clk_div, clk_enable} !== 2'b00) begin bad++; $display("FAIL err5_cnt2: got %b want 00", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if (select_err !== 1'b0) begin bad++; $display("FAIL err5_once: got %b want 0", select_err); end
        select_req = 1'b1;
        select = 3'd7;
        @(negedge clk);
        select_req = 1'b0;
        total++; if (select_err !== 1'b1) begin bad++; $display("FAIL err7_pulse: got %b want 1", select_err); end
        total++; if (clk_enable !== 1'b1) begin bad++; $display("FAIL err_phase: got %b want 1", clk_enable); end
        @(negedge clk);
        total++; if (select_ack !== 1'b0) begin bad++; $display("FAIL err_no_ack: got %b want 0", select_ack); end
    endtask

    // R0 lowered 9->2 with counter at 6: immediate wrap then period 3
    task automatic test_ratio_change();
        div_ratio = '0;
        set_r(0, 9);
        reset_dut();
        repeat (6) @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b00) begin bad++; $display("FAIL rc_c6: got %b want 00", {clk_div, clk_enable}); end
        set_r(0, 2);
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b11) begin bad++; $display("FAIL rc_wrap: got %b want 11", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b10) begin bad++; $display("FAIL rc_c1: got %b want 10", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b00) begin bad++; $display("FAIL rc_c2: got %b want 00", {clk_div, clk_enable}); end
        @(negedge clk);
        total++; if ({clk_div, clk_enable} !== 2'b11) begin bad++; $display("FAIL rc_c0: got %b want 11", {clk_div, clk_enable}); end
    endtask

    // second request while pending is ignored, also in the cycle the switch lands
    task automatic test_second_req();
        int acks;
        div_ratio = '0;
        set_r(0, 3);
        set_r(1, 1);
        set_r(2, 2);
        reset_dut();
        acks = 0;
        @(negedge clk);
        select_req = 1'b1;
        select = 3'd2;
        @(negedge clk);
        select = 3'd1;
        @(negedge clk);
        total++; if (select_ready !== 1'b0) begin bad++; $display("FAIL sr_ready: got %b want 0", select_ready); end
        @(negedge clk);
        select_req = 1'b0;
        acks += int'(select_ack);
        total++; if (current_select !== 3'd2) begin bad++; $display("FAIL sr_sel: got %0d want 2", current_select); end
        total++; if (select_ready !== 1'b1) begin bad++; $display("FAIL sr_not_taken: got %b want 1", select_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            acks += int'(select_ack);
        end
        total++; if (clk_enable !== 1'b1) begin bad++; $display("FAIL sr_r2_period: got %b want 1", clk_enable); end
        total++; if (current_select !== 3'd2) begin bad++; $display("FAIL sr_sel_kept: got %0d want 2", current_select); end
        total++; if (acks !== 1) begin bad++; $display("FAIL sr_ack_count: got %0d want 1", acks); end
    endtask

    task automatic test_reset_mid();
        int acks;
        logic [3:0] en_seen;
        div_ratio = '0;
        set_r(0, 3);
        set_r(1, 1);
        reset_dut();
        acks = 0;
        @(negedge clk);
        select_req = 1'b1;
        select = 3'd1;
        @(negedge clk);
        select_req = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (select_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", select_ready); end
        total++; if (clk_enable !== 1'b0) begin bad++; $display("FAIL rm_en: got %b want 0", clk_enable); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            acks += int'(select_ack);
            en_seen[k] = clk_enable;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL rm_no_ack: got %0d want 0", acks); end
        total++; if (current_select !== 3'd0) begin bad++; $display("FAIL rm_sel: got %0d want 0", current_select); end
        total++; if (en_seen !== 4'b1000) begin bad++; $display("FAIL rm_restart: got %b want 1000", en_seen); end
    endtask

    task automatic test_edges();
        int en_cnt;
        int div_cnt;
        int first_en;
        div_ratio = '0;
        reset_dut();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if ({clk_div, clk_enable} !== 2'b11) begin bad++; $display("FAIL r0_const[%0d]: got %b want 11", k, {clk_div, clk_enable}); end
        end
        set_r(0, 255);
        reset_dut();
        en_cnt = 0;
        div_cnt = 0;
        first_en = 0;
        for (int k = 1; k <= 512; k++) begin
            @(negedge clk);
            en_cnt += int'(clk_enable);
            div_cnt += int'(clk_div);
            if (clk_enable && first_en == 0) first_en = k;
        end
        total++; if (first_en !== 256) begin bad++; $display("FAIL r255_period: got %0d want 256", first_en); end
        total++; if (en_cnt !== 2) begin bad++; $display("FAIL r255_pulses: got %0d want 2", en_cnt); end
        total++; if (div_cnt !== 256) begin bad++; $display("FAIL r255_high: got %0d want 256", div_cnt); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        div_ratio = '0;
        select_req = 1'b0;
        select = 3'd0;
        total = 0;
        bad = 0;
        test_reset();
        test_div3();
        test_switch();
        test_err();
        test_ratio_change();
        test_second_req();
        test_reset_mid();
        test_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
